turbo_steuerung: RTL
====================

Name: turbo_steuerung

Overview:
Upstream control stage that produces the turbo signal for the colour-change stage and for the ball-speed logic. It counts paddle hits within a rally and asserts turbo once a hit threshold is reached. Turbo is held for a fixed number of video frames, followed by a cooldown. A lost ball ends the rally and cancels everything.

Parameters:
HITS_FOR_TURBO, 5, consecutive paddle hits in one rally that trigger turbo (1..2^CNT_W-1)
TURBO_FRAMES, 300, number of frame_tick pulses turbo stays high (>=1)
COOLDOWN_FRAMES, 120, frame_tick pulses after turbo during which hits are not counted (>=1)
CNT_W, 4, width of the hit counter
FRM_W, 9, width of the frame down-counter (must hold max(TURBO_FRAMES, COOLDOWN_FRAMES)-1)

Ports:
clk  in  1  system clock (pixel/game clock)
reset_n  in  1  synchronous reset, active low
frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
paddle_hit  in  1  one-cycle pulse: ball reflected by either paddle
ball_lost  in  1  one-cycle pulse: point scored, rally over
turbo  out  1  high while in TURBO state; registered
turbo_start  out  1  one-cycle pulse on the cycle turbo rises; registered
hit_count  out  CNT_W  hits counted in the current rally; registered

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clk). All state updates on rising clk.
- Reset values: state=COUNT, hit_count=0, frame counter=0, turbo=0, turbo_start=0.
- States: COUNT, TURBO, COOLDOWN (2-bit encoding).
- COUNT:
  - paddle_hit increments hit_count.
  - If hit_count+1 == HITS_FOR_TURBO: next state TURBO, frame counter loaded with TURBO_FRAMES-1, turbo=1 and turbo_start=1 on the next cycle. Latency from hit pulse to turbo high: 1 cycle.
  - frame_tick is ignored in COUNT.
- TURBO:
  - hit_count holds at HITS_FOR_TURBO; further hits are ignored (no wrap).
  - frame_tick with counter>0 decrements the counter.
  - frame_tick with counter==0 goes to COOLDOWN, loads COOLDOWN_FRAMES-1, and drops turbo next cycle. Turbo therefore spans exactly TURBO_FRAMES frame_tick pulses.
- COOLDOWN:
  - Hits are ignored; hit_count holds.
  - frame_tick decrements the counter as in TURBO.
  - At expiry: go to COUNT with hit_count=0.
- ball_lost in any state: next state COUNT, hit_count=0, counter=0, turbo=0, turbo_start=0. It has priority over paddle_hit and frame_tick in the same cycle.
- paddle_hit and frame_tick in the same cycle: both are evaluated per their state rules. A hit that triggers turbo and a coincident frame_tick does not decrement the freshly loaded counter.
- turbo_start is high for exactly one cycle per COUNT->TURBO transition and is never high without turbo.
- Reset asserted mid-TURBO: turbo low on the cycle after reset_n is sampled low.
- hit_count never exceeds HITS_FOR_TURBO.

Decomposition:
- Shared pong package holds: the state encoding constants (ST_COUNT=0, ST_TURBO=1, ST_COOLDOWN=2) and the default HITS_FOR_TURBO/TURBO_FRAMES/COOLDOWN_FRAMES values, so the speed logic and the colour-change stage use the same numbers.
- One sub-module is natural: frame_countdown. It is a loadable down-counter with load, dec and zero outputs, shared by the TURBO and COOLDOWN states.
- The FSM and hit counter stay in the top block.

Test Plan:
(Bench parameters: HITS_FOR_TURBO=3, TURBO_FRAMES=4, COOLDOWN_FRAMES=2.)
- Reset, then 3 paddle_hit pulses 5 cycles apart -> hit_count 1, 2, 3. turbo rises exactly 1 cycle after the 3rd hit. turbo_start is high for that single cycle.
- In TURBO, apply 4 frame_tick pulses plus 2 extra paddle_hit pulses -> turbo falls 1 cycle after the 4th tick; hit_count stays 3.
- In COOLDOWN, apply 2 hits then 2 frame_ticks -> hits ignored. After the 2nd tick, state=COUNT and hit_count=0. The next 3 hits retrigger turbo.
- After 2 hits, assert ball_lost and paddle_hit in the same cycle -> hit_count=0, no turbo. A ball_lost during TURBO drops turbo next cycle.
- paddle_hit (3rd) coincident with frame_tick -> turbo rises and still lasts exactly 4 further frame_ticks.
- reset_n low for 1 cycle mid-TURBO -> turbo, turbo_start and hit_count are all 0 the following cycle; state=COUNT.

Source files
------------

// File: rtl/turbo_steuerung_pkg.sv
// Shared pong control package: turbo FSM state encoding and the default
// turbo timing numbers used by the speed logic and the colour-change stage.
package turbo_steuerung_pkg;

  // Turbo controller state encoding (2-bit)
  typedef enum logic [1:0] {
    ST_COUNT    = 2'd0,
    ST_TURBO    = 2'd1,
    ST_COOLDOWN = 2'd2
  } turbo_state_t;

  // Default game tuning, shared by every consumer of the turbo signal
  localparam int DEF_HITS_FOR_TURBO  = 5;
  localparam int DEF_TURBO_FRAMES    = 300;
  localparam int DEF_COOLDOWN_FRAMES = 120;
  localparam int DEF_CNT_W           = 4;
  localparam int DEF_FRM_W           = 9;

endpackage : turbo_steuerung_pkg

// File: rtl/turbo_steuerung_frame_countdown.sv
// Loadable frame down-counter shared by the TURBO and COOLDOWN phases.
// Priority: clear over load over decrement. zero reflects the stored count.
module turbo_steuerung_frame_countdown #(
  parameter int FRM_W = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [FRM_W-1:0] load_val,
  input  logic             dec,
  output logic [FRM_W-1:0] cnt,
  output logic             zero
);

  logic [FRM_W-1:0] cnt_r;

  // Count register: synchronous reset, clear, load, or decrement (never below 0)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= {FRM_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {FRM_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {FRM_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(FRM_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {FRM_W{1'b0}});

endmodule : turbo_steuerung_frame_countdown

// File: rtl/turbo_steuerung.sv
// Turbo controller: counts paddle hits within a rally, raises turbo for a
// fixed number of frames once the hit threshold is reached, then enforces a
// cooldown. A lost ball ends the rally and cancels everything immediately.
module turbo_steuerung
  import turbo_steuerung_pkg::*;
#(
  parameter int HITS_FOR_TURBO  = DEF_HITS_FOR_TURBO,
  parameter int TURBO_FRAMES    = DEF_TURBO_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int FRM_W           = DEF_FRM_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             paddle_hit,
  input  logic             ball_lost,
  output logic             turbo,
  output logic             turbo_start,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] HITS_C      = CNT_W'(HITS_FOR_TURBO);
  localparam logic [FRM_W-1:0] TURBO_LD_C  = FRM_W'(TURBO_FRAMES - 1);
  localparam logic [FRM_W-1:0] COOL_LD_C   = FRM_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  turbo_state_t     state_r;
  logic [CNT_W-1:0] hit_count_r;
  logic             turbo_r;
  logic             turbo_start_r;

  logic [CNT_W-1:0] hit_next_s;
  logic             hit_trigger_s;
  logic             fc_clr_s;
  logic             fc_load_s;
  logic             fc_dec_s;
  logic [FRM_W-1:0] fc_load_val_s;
  logic [FRM_W-1:0] fc_cnt_s;
  logic             fc_zero_s;

  assign hit_next_s    = hit_count_r + CNT_ONE_C;
  assign hit_trigger_s = paddle_hit && (hit_next_s == HITS_C);

  // Frame counter control: load on phase entry, decrement on ticks, clear on rally end
  always_comb begin
    fc_clr_s      = 1'b0;
    fc_load_s     = 1'b0;
    fc_dec_s      = 1'b0;
    fc_load_val_s = {FRM_W{1'b0}};
    if (ball_lost) begin
      fc_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_COUNT: begin
          // A coincident frame_tick must not touch the freshly loaded count
          if (hit_trigger_s) begin
            fc_load_s     = 1'b1;
            fc_load_val_s = TURBO_LD_C;
          end else begin
            fc_load_s = 1'b0;
          end
        end
        ST_TURBO: begin
          if (frame_tick && fc_zero_s) begin
            fc_load_s     = 1'b1;
            fc_load_val_s = COOL_LD_C;
          end else if (frame_tick) begin
            fc_dec_s = 1'b1;
          end else begin
            fc_dec_s = 1'b0;
          end
        end
        ST_COOLDOWN: begin
          if (frame_tick && fc_zero_s) begin
            fc_clr_s = 1'b1;
          end else if (frame_tick) begin
            fc_dec_s = 1'b1;
          end else begin
            fc_dec_s = 1'b0;
          end
        end
        default: begin
          fc_clr_s = 1'b1;
        end
      endcase
    end
  end

  turbo_steuerung_frame_countdown #(
    .FRM_W (FRM_W)
  ) u_frame_countdown (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (fc_clr_s),
    .load     (fc_load_s),
    .load_val (fc_load_val_s),
    .dec      (fc_dec_s),
    .cnt      (fc_cnt_s),
    .zero     (fc_zero_s)
  );

  // Turbo FSM with hit counter and registered turbo/turbo_start outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_COUNT;
      hit_count_r   <= {CNT_W{1'b0}};
      turbo_r       <= 1'b0;
      turbo_start_r <= 1'b0;
    end else begin
      turbo_start_r <= 1'b0;
      if (ball_lost) begin
        state_r     <= ST_COUNT;
        hit_count_r <= {CNT_W{1'b0}};
        turbo_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_COUNT: begin
            turbo_r <= 1'b0;
            if (hit_trigger_s) begin
              hit_count_r   <= hit_next_s;
              state_r       <= ST_TURBO;
              turbo_r       <= 1'b1;
              turbo_start_r <= 1'b1;
            end else if (paddle_hit) begin
              hit_count_r <= hit_next_s;
            end else begin
              hit_count_r <= hit_count_r;
            end
          end
          ST_TURBO: begin
            // Hits are ignored here; hit_count stays at the threshold
            if (frame_tick && fc_zero_s) begin
              state_r <= ST_COOLDOWN;
              turbo_r <= 1'b0;
            end else begin
              turbo_r <= 1'b1;
            end
          end
          ST_COOLDOWN: begin
            turbo_r <= 1'b0;
            if (frame_tick && fc_zero_s) begin
              state_r     <= ST_COUNT;
              hit_count_r <= {CNT_W{1'b0}};
            end else begin
              state_r <= ST_COOLDOWN;
            end
          end
          default: begin
            state_r     <= ST_COUNT;
            hit_count_r <= {CNT_W{1'b0}};
            turbo_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign turbo       = turbo_r;
  assign turbo_start = turbo_start_r;
  assign hit_count   = hit_count_r;

endmodule : turbo_steuerung
